// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: receiver state encoding and the
//            oversampling constants used by both receiver and transmitter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int OVERSAMPLE = 16;  // ticks per bit
   localparam int HALF_BIT   = 7;   // tick count at the start-bit midpoint
   localparam int DATA_BITS  = 8;   // payload bits per frame

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Bundles the receiver's line/strobe inputs and its result outputs.
// Signals  : tick      - 16x-baud strobe, one clk wide
//            rxd       - asynchronous serial line, idle high
//            data_out  - last correctly framed byte
//            rx_done   - one-cycle pulse when data_out updates
//            frame_err - one-cycle pulse on a stop bit sampled low
//            rx_busy   - high whenever the receiver is not idle
// Modports : master (drives line and strobe), slave (the receiver)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
   import uart_pkg::*;

   logic                 tick;
   logic                 rxd;
   logic [DATA_BITS-1:0] data_out;
   logic                 rx_done;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (
      output tick, rxd,
      input  data_out, rx_done, frame_err, rx_busy
   );

   modport slave (
      input  tick, rxd,
      output data_out, rx_done, frame_err, rx_busy
   );

endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Purpose  : Two-flop synchronizer for the asynchronous serial line. Both
//            flops reset to 1 so the idle line never looks like a start bit.
// Ports    : clk - clock
//            rst - synchronous active-high reset
//            d   - asynchronous input
//            q   - synchronized output (2 clk latency)
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic d,
   output logic      q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 16x oversampling. Start bit is checked at
//            its midpoint, then every data bit and the stop bit are sampled
//            one full bit period later, i.e. at their midpoints.
// Ports    : clk - clock
//            rst - synchronous active-high reset
//            bus - uart_rx_if.slave (tick, rxd in; data_out, rx_done,
//                  frame_err, rx_busy out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   uart_rx_if.slave  bus
);

   localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] S_HALF = 4'(HALF_BIT);
   localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

   logic                 rxd_s;
   uart_rx_state_t       state;
   logic [3:0]           s_cnt;
   logic [2:0]           n;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] data_out;
   logic                 rx_done;
   logic                 frame_err;

   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rxd),
      .q   (rxd_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         s_cnt     <= 4'd0;
         n         <= 3'd0;
         shreg     <= '0;
         data_out  <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               // Start detection does not wait for a tick, so a start edge
               // right after a stop bit is caught immediately.
               if (!rxd_s) begin
                  state <= START;
                  s_cnt <= 4'd0;
               end
            end
            START: begin
               if (bus.tick) begin
                  if (s_cnt == S_HALF) begin
                     if (!rxd_s) begin
                        state <= DATA;
                        s_cnt <= 4'd0;
                        n     <= 3'd0;
                     end else begin
                        state <= IDLE;    // line went back high: glitch
                     end
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (bus.tick) begin
                  if (s_cnt == S_LAST) begin
                     // LSB arrives first, so shift in from the top.
                     shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                     s_cnt <= 4'd0;
                     if (n == N_LAST) begin
                        state <= STOP;
                     end else begin
                        n <= n + 3'd1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            STOP: begin
               if (bus.tick) begin
                  if (s_cnt == S_LAST) begin
                     if (rxd_s) begin
                        data_out <= shreg;
                        rx_done  <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                     end
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must release before a new start bit
               // can be recognised.
               if (rxd_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_out  = data_out;
   assign bus.rx_done   = rx_done;
   assign bus.frame_err = frame_err;
   assign bus.rx_busy   = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx. A simple bit-serial
//            driver sharing the receiver's tick stands in for the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   done_cnt = 0;
   int   ferr_cnt = 0;
   int   both_cnt = 0;
   int   tdiv = 0;
   int   d0, f0;

   uart_rx_if bus ();

   uart_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // One tick every 4 clocks, changed on the falling edge.
   initial bus.tick = 1'b0;
   always @(negedge clk) begin
      tdiv = (tdiv == 3) ? 0 : tdiv + 1;
      bus.tick = (tdiv == 0);
   end

   // Pulse monitors sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) done_cnt++;
      if (bus.frame_err === 1'b1) ferr_cnt++;
      if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for n ticks; returns 1 ns after the clock edge carrying the last one.
   task automatic wait_ticks(input int nt);
      repeat (nt) begin
         @(posedge clk);
         while (bus.tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      bus.rxd = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         wait_ticks(16);
      end
      bus.rxd = stop_bit;
      wait_ticks(16);
   endtask

   initial begin
      bus.rxd = 1'b1;
      rst     = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_data_out",  32'(bus.data_out), 32'h00);
      check("reset_rx_done",   32'(bus.rx_done),  32'h0);
      check("reset_frame_err", 32'(bus.frame_err), 32'h0);
      check("reset_rx_busy",   32'(bus.rx_busy),  32'h0);
      wait_ticks(4);

      // Clean frame 0xA5
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1);
      check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("a5_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
      check("a5_data",        32'(bus.data_out),  32'hA5);
      check("a5_idle",        32'(bus.rx_busy),   32'h0);
      wait_ticks(8);

      // Short low glitch
      d0 = done_cnt; f0 = ferr_cnt;
      bus.rxd = 1'b0;
      wait_ticks(4);
      bus.rxd = 1'b1;
      wait_ticks(20);
      check("glitch_done_pulses", 32'(done_cnt - d0), 32'd0);
      check("glitch_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
      check("glitch_data",        32'(bus.data_out),  32'hA5);
      check("glitch_idle",        32'(bus.rx_busy),   32'h0);

      // 0x3C with bad stop bit, then break for 40 ticks
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      wait_ticks(40);
      check("break_busy",        32'(bus.rx_busy),   32'h1);
      check("break_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
      check("break_done_pulses", 32'(done_cnt - d0), 32'd0);
      check("break_data",        32'(bus.data_out),  32'hA5);
      bus.rxd = 1'b1;
      wait_ticks(2);
      check("break_release_idle", 32'(bus.rx_busy),   32'h0);
      check("break_ferr_total",   32'(ferr_cnt - f0), 32'd1);
      wait_ticks(8);

      // Back-to-back 0x00 then 0xFF
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h00, 1'b1);
      check("b2b_first_data",  32'(bus.data_out),  32'h00);
      check("b2b_first_done",  32'(done_cnt - d0), 32'd1);
      send_frame(8'hFF, 1'b1);
      check("b2b_second_data", 32'(bus.data_out),  32'hFF);
      check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
      check("b2b_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
      wait_ticks(8);

      // Reset during bit 4 of 0x5A; line then returns idle
      d0 = done_cnt; f0 = ferr_cnt;
      bus.rxd = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = 1'(8'h5A >> i);
         wait_ticks(16);
      end
      bus.rxd = 1'b1;          // bit 4 of 0x5A
      wait_ticks(8);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_ticks(30);
      check("rst_done_pulses", 32'(done_cnt - d0), 32'd0);
      check("rst_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
      check("rst_data_cleared", 32'(bus.data_out), 32'h00);
      check("rst_idle",        32'(bus.rx_busy),   32'h0);
      d0 = done_cnt;
      send_frame(8'h81, 1'b1);
      check("after_rst_data", 32'(bus.data_out),  32'h81);
      check("after_rst_done", 32'(done_cnt - d0), 32'd1);
      wait_ticks(8);

      // Loopback-style frame 0xC3 on the shared tick
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'hC3, 1'b1);
      check("loop_data", 32'(bus.data_out),  32'hC3);
      check("loop_done", 32'(done_cnt - d0), 32'd1);
      check("loop_ferr", 32'(ferr_cnt - f0), 32'd0);

      check("never_both_pulses", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port tick, input, 1 bit: 16x-baud oversampling strobe, one clk wide; it is the same strobe that drives the transmitter.
REQ-004 SHALL have port rxd, input, 1 bit: asynchronous serial line; idle level is 1.
REQ-005 SHALL have port data_out, output, 8 bits: last correctly framed byte.
REQ-006 SHALL have port rx_done, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-007 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-008 SHALL have port rx_busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer; all decisions SHALL use the synchronized signal rxd_s, which lags rxd by 2 clk cycles.
REQ-010 SHALL implement five states: IDLE, START, DATA, STOP, WAIT_HIGH. The 4-bit tick counter s_cnt and the 3-bit bit counter n SHALL advance only on cycles where tick=1.
REQ-011 IDLE: when rxd_s=0, go to START and set s_cnt=0; a tick is not required for this transition.
REQ-012 START: on a tick with s_cnt=7 (the start-bit midpoint), go to DATA with s_cnt=0 and n=0 if rxd_s=0; if rxd_s=1, return to IDLE (glitch rejected). On any other tick, s_cnt+1.
REQ-013 DATA: on a tick with s_cnt=15, shift rxd_s into bit 7 of the shift register (LSB-first line order) and set s_cnt=0. If n=7, go to STOP; otherwise n+1. On any other tick, s_cnt+1.
REQ-014 STOP: on a tick with s_cnt=15, the next state depends on rxd_s.
  - rxd_s=1: load data_out from the shift register, pulse rx_done, go to IDLE.
  - rxd_s=0: pulse frame_err, leave data_out unchanged, go to WAIT_HIGH.
REQ-015 WAIT_HIGH: stay until rxd_s=1, then go to IDLE; a held-low line (break) SHALL NOT be taken as a new start bit.
REQ-016 rx_done and frame_err SHALL be registered, SHALL assert in the cycle after the deciding tick, and SHALL never be high together.
REQ-017 SHALL accept back-to-back frames: a start edge arriving in the first IDLE cycle after STOP SHALL be detected.
REQ-018 Counter wrap: s_cnt and n SHALL never count past 15 and 7; they are reloaded at each state entry.
REQ-019 tick held at 0 SHALL freeze all counters and states except the IDLE->START and WAIT_HIGH->IDLE transitions.

Reset
REQ-020 rst=1 SHALL force state=IDLE, s_cnt=0, n=0, shift register=0x00, data_out=0x00, rx_done=0, frame_err=0, synchronizer flops=1.
REQ-021 rst asserted mid-frame SHALL abandon the frame with no rx_done or frame_err pulse; reception SHALL resume on the next falling edge after release.

Structure
REQ-022 The shared package uart_pkg SHALL hold the state enum (uart_rx_state_t), OVERSAMPLE=16, HALF_BIT=7 and DATA_BITS=8, reusable by the transmitter.
REQ-023 The synchronizer SHALL be a separate sub-module uart_sync (2 flops, reset value 1); everything else SHALL live in uart_rx.

Verification
REQ-024 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks per bit -> exactly one rx_done pulse, data_out=0xA5, frame_err stays 0.
REQ-025 rxd low for only 4 ticks, then high -> return to IDLE, no rx_done, no frame_err, data_out unchanged.
REQ-026 Byte 0x3C with stop bit 0, then line held low for 40 ticks -> one frame_err pulse, data_out keeps its previous value, rx_busy=1 until rxd_s rises.
REQ-027 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses; data_out=0x00 after the first and 0xFF after the second.
REQ-028 rst pulsed during bit 4 of frame 0x5A -> no pulses from that frame; a following 0x81 frame is received correctly.
REQ-029 Loopback from the transmitter's txd driven with 0xC3 and sharing the same tick -> rx_done pulse with data_out=0xC3.
